mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = m0 always wins conflicts.
REQ-002 Parameter CNT_W, default 16: width of the conflict counter.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 m0_addr  input  32  master 0 (CPU) byte address.
REQ-006 m0_wdata  input  32  master 0 write data.
REQ-007 m0_wmask  input  4  master 0 byte write enables.
REQ-008 m0_rstrb  input  1  master 0 read strobe.
REQ-009 m0_ready  output  1  master 0 request accepted this cycle.
REQ-010 m0_rvalid  output  1  master 0 read data valid.
REQ-011 m0_rdata  output  32  master 0 read data.
REQ-012 m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_ready, m1_rvalid, m1_rdata SHALL mirror REQ-005..011 for master 1 (loader/DMA).
REQ-013 s_addr  output  32  RAM address.
REQ-014 s_wdata  output  32  RAM write data.
REQ-015 s_wmask  output  4  RAM byte write enables.
REQ-016 s_rstrb  output  1  RAM read strobe.
REQ-017 s_rdata  input  32  RAM read data, valid one cycle after s_rstrb.
REQ-018 conflict_cnt  output  CNT_W  count of cycles with both masters requesting.

Function
REQ-019 Request for master n SHALL be: mn_rstrb OR (mn_wmask != 0).
REQ-020 Grant SHALL be combinational in the request cycle; mn_ready = 1 only for the granted master; at most one of m0_ready and m1_ready is high.
REQ-021 Only one master requesting: that master SHALL be granted.
REQ-022 Both requesting, FIXED_PRIO=0: grant SHALL go to the master not recorded in the last_grant register.
REQ-023 Both requesting, FIXED_PRIO=1: grant SHALL go to m0.
REQ-024 last_grant SHALL update on every cycle with a grant; it holds its value when idle.
REQ-025 s_addr, s_wdata, s_wmask, s_rstrb SHALL carry the granted master's signals.
REQ-026 With no grant: s_rstrb = 0, s_wmask = 0, s_addr/s_wdata = m0 values.
REQ-027 A master with rstrb and wmask both set SHALL be forwarded as-is (write plus read); its rvalid returns the RAM's read data.
REQ-028 The arbiter SHALL accept a new request every cycle; back-to-back grants are allowed, including alternating masters.
REQ-029 Accepted reads SHALL be tracked in rd_pend (1 bit) and rd_owner (1 bit).
REQ-030 mn_rvalid SHALL be 1 exactly one cycle after an accepted read by master n.
REQ-031 mn_rdata SHALL equal s_rdata when mn_rvalid = 1, else 0.
REQ-032 Write-only grants SHALL NOT assert rvalid.
REQ-033 A non-granted master SHALL hold its request stable until ready; the arbiter does not latch denied requests.
REQ-034 conflict_cnt SHALL increment each cycle both masters request, and saturate at all-ones.

Reset
REQ-035 While resetn = 0 at a rising edge: last_grant <= m1 (m0 wins the first round-robin conflict), rd_pend <= 0, conflict_cnt <= 0.
REQ-036 While resetn = 0: m0_ready, m1_ready, s_rstrb, s_wmask, m0_rvalid, m1_rvalid SHALL be 0.
REQ-037 Reset asserted with a read in flight: the pending rvalid SHALL be suppressed and not emitted after reset release.
REQ-038 The first request in the cycle after resetn rises SHALL be granted normally.

Verification
REQ-039 m0 read at 0x10 alone, RAM word 0x10 = 0xDEADBEEF -> m0_ready same cycle; m0_rvalid next cycle with m0_rdata = 0xDEADBEEF; m1_rvalid = 0.
REQ-040 FIXED_PRIO=0, both reading continuously from reset -> grants m0, m1, m0, m1; each rvalid one cycle after its grant; conflict_cnt = 4 after 4 cycles.
REQ-041 FIXED_PRIO=1, both requesting for 5 cycles -> m0_ready = 1 all 5 cycles, m1_ready = 0; m1 granted in the first cycle m0 is idle.
REQ-042 m1 write wmask = 4'b0100 with data 0x00AB0000 to 0x20, then m0 read of 0x20 -> s_wmask = 0100 during the write; no rvalid for the write; m0 reads byte 2 = 0xAB.
REQ-043 resetn pulsed low in the cycle after an m0 read grant -> m0_rvalid stays 0; after release m1 wins the first conflict only if last_grant = m0, else m0 wins (per REQ-035).
REQ-044 CNT_W=4, conflicts held for 20 cycles -> conflict_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two-master / one-RAM bus bundle for mem_arbiter.
// The arbiter uses the slave modport; the surrounding system (masters and RAM) uses master.
interface mem_arbiter_if;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb;
  logic        m0_ready;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb;
  logic        m1_ready;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output m1_ready, m1_rvalid, m1_rdata,
    output s_addr, s_wdata, s_wmask, s_rstrb,
    input  s_rdata
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  s_addr, s_wdata, s_wmask, s_rstrb,
    output s_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter: combinational grant, one-cycle read return,
// round-robin or fixed m0 priority, saturating conflict counter.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic             req0_s, req1_s;
  logic             grant0_s, grant1_s;
  logic             rd_accept_s;
  logic             rvalid0_s, rvalid1_s;
  logic             last_grant_r;   // 1 = m1 was served last
  logic             rd_pend_r;
  logic             rd_owner_r;     // 1 = pending read belongs to m1
  logic [CNT_W-1:0] cnt_r;

  // Request decode and grant selection
  always_comb begin
    req0_s   = bus.m0_rstrb | (bus.m0_wmask != 4'b0000);
    req1_s   = bus.m1_rstrb | (bus.m1_wmask != 4'b0000);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (resetn) begin
      case ({req0_s, req1_s})
        2'b10: grant0_s = 1'b1;
        2'b01: grant1_s = 1'b1;
        2'b11: begin
          if (FIXED_PRIO || last_grant_r) grant0_s = 1'b1;
          else                            grant1_s = 1'b1;
        end
        default: begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      endcase
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    rd_accept_s = (grant0_s & bus.m0_rstrb) | (grant1_s & bus.m1_rstrb);
  end

  // RAM-side mux and per-master responses
  always_comb begin
    bus.m0_ready = grant0_s;
    bus.m1_ready = grant1_s;
    if (grant1_s) begin
      bus.s_addr  = bus.m1_addr;
      bus.s_wdata = bus.m1_wdata;
      bus.s_wmask = bus.m1_wmask;
      bus.s_rstrb = bus.m1_rstrb;
    end else if (grant0_s) begin
      bus.s_addr  = bus.m0_addr;
      bus.s_wdata = bus.m0_wdata;
      bus.s_wmask = bus.m0_wmask;
      bus.s_rstrb = bus.m0_rstrb;
    end else begin
      bus.s_addr  = bus.m0_addr;
      bus.s_wdata = bus.m0_wdata;
      bus.s_wmask = 4'b0000;
      bus.s_rstrb = 1'b0;
    end
    // Gated by resetn so a read in flight when reset hits never surfaces
    rvalid0_s     = resetn & rd_pend_r & ~rd_owner_r;
    rvalid1_s     = resetn & rd_pend_r & rd_owner_r;
    bus.m0_rvalid = rvalid0_s;
    bus.m1_rvalid = rvalid1_s;
    bus.m0_rdata  = rvalid0_s ? bus.s_rdata : 32'h0000_0000;
    bus.m1_rdata  = rvalid1_s ? bus.s_rdata : 32'h0000_0000;
  end

  // Arbitration history, read tracking and conflict counting
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_r <= 1'b1;
      rd_pend_r    <= 1'b0;
      rd_owner_r   <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      if (grant0_s || grant1_s) last_grant_r <= grant1_s;
      else                      last_grant_r <= last_grant_r;
      rd_pend_r <= rd_accept_s;
      if (rd_accept_s) rd_owner_r <= grant1_s;
      else             rd_owner_r <= rd_owner_r;
      if (req0_s && req1_s && (cnt_r != {CNT_W{1'b1}}))
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        cnt_r <= cnt_r;
    end
  end

  assign conflict_cnt = cnt_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin (CNT_W=4) and fixed-priority instances,
// grant checks at request time, read returns checked by a queue-driven monitor.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus_rr();
  mem_arbiter_if bus_fp();
  logic [3:0]  cnt_rr;
  logic [15:0] cnt_fp;

  mem_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(4)) dut_rr (
    .clk(clk), .resetn(resetn), .bus(bus_rr), .conflict_cnt(cnt_rr));
  mem_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(16)) dut_fp (
    .clk(clk), .resetn(resetn), .bus(bus_fp), .conflict_cnt(cnt_fp));

  // RAM models: one-cycle read latency, read returns pre-write contents
  logic [31:0] mem_rr [0:63];
  logic [31:0] mem_fp [0:63];
  logic [31:0] rd_rr = 32'h0, rd_fp = 32'h0;
  assign bus_rr.s_rdata = rd_rr;
  assign bus_fp.s_rdata = rd_fp;

  always @(posedge clk) begin
    if (bus_rr.s_rstrb) rd_rr <= mem_rr[bus_rr.s_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (bus_rr.s_wmask[b]) mem_rr[bus_rr.s_addr[7:2]][8*b +: 8] <= bus_rr.s_wdata[8*b +: 8];
  end

  always @(posedge clk) begin
    if (bus_fp.s_rstrb) rd_fp <= mem_fp[bus_fp.s_addr[7:2]];
    for (int k = 0; k < 4; k++)
      if (bus_fp.s_wmask[k]) mem_fp[bus_fp.s_addr[7:2]][8*k +: 8] <= bus_fp.s_wdata[8*k +: 8];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int active = 0;  // 0 = round-robin instance under check, 1 = fixed-priority
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_r0, a_r1, a_v0, a_v1, a_srstrb;
  logic [31:0] a_d0, a_d1, a_saddr, a_swdata;
  logic [3:0]  a_swmask;
  logic [15:0] a_cnt;

  always_comb begin
    if (active == 1) begin
      a_r0 = bus_fp.m0_ready;  a_r1 = bus_fp.m1_ready;
      a_v0 = bus_fp.m0_rvalid; a_v1 = bus_fp.m1_rvalid;
      a_d0 = bus_fp.m0_rdata;  a_d1 = bus_fp.m1_rdata;
      a_saddr = bus_fp.s_addr; a_swdata = bus_fp.s_wdata;
      a_swmask = bus_fp.s_wmask; a_srstrb = bus_fp.s_rstrb;
      a_cnt = cnt_fp;
    end else begin
      a_r0 = bus_rr.m0_ready;  a_r1 = bus_rr.m1_ready;
      a_v0 = bus_rr.m0_rvalid; a_v1 = bus_rr.m1_rvalid;
      a_d0 = bus_rr.m0_rdata;  a_d1 = bus_rr.m1_rdata;
      a_saddr = bus_rr.s_addr; a_swdata = bus_rr.s_wdata;
      a_swmask = bus_rr.s_wmask; a_srstrb = bus_rr.s_rstrb;
      a_cnt = {12'h000, cnt_rr};
    end
  end

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops one expected read response; overdue entries are misses
  always @(negedge clk) begin
    exp_t e;
    if (a_v0 || a_v1) begin
      chk("rvalid_onehot", {31'h0, a_v0 & a_v1}, 32'h0);
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", {30'h0, a_v1, a_v0}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rvalid_owner", {31'h0, a_v1}, {31'h0, e.owner});
        chk("rvalid_cycle", cyc, e.due);
        chk("rdata", e.owner ? a_d1 : a_d0, e.data);
        chk("rdata_other_zero", e.owner ? a_d0 : a_d1, 32'h0);
      end
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      chk("rvalid_missing", 32'h0, {31'h0, 1'b1});
    end
  end

  // One bus cycle on both instances; g: 0 = no grant, 1 = m0, 2 = m1
  task automatic step(input logic rn,
                      input logic r0, input logic [3:0] w0, input logic [31:0] ad0, input logic [31:0] d0,
                      input logic r1, input logic [3:0] w1, input logic [31:0] ad1, input logic [31:0] d1,
                      input int g, input logic [31:0] exp_rd, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn;
    bus_rr.m0_rstrb = r0; bus_rr.m0_wmask = w0; bus_rr.m0_addr = ad0; bus_rr.m0_wdata = d0;
    bus_rr.m1_rstrb = r1; bus_rr.m1_wmask = w1; bus_rr.m1_addr = ad1; bus_rr.m1_wdata = d1;
    bus_fp.m0_rstrb = r0; bus_fp.m0_wmask = w0; bus_fp.m0_addr = ad0; bus_fp.m0_wdata = d0;
    bus_fp.m1_rstrb = r1; bus_fp.m1_wmask = w1; bus_fp.m1_addr = ad1; bus_fp.m1_wdata = d1;
    @(negedge clk);
    chk({tag, "_m0_ready"}, {31'h0, a_r0}, {31'h0, (g == 1)});
    chk({tag, "_m1_ready"}, {31'h0, a_r1}, {31'h0, (g == 2)});
    if (g == 1) begin
      chk({tag, "_s_addr"}, a_saddr, ad0);
      chk({tag, "_s_wdata"}, a_swdata, d0);
      chk({tag, "_s_wmask"}, {28'h0, a_swmask}, {28'h0, w0});
      chk({tag, "_s_rstrb"}, {31'h0, a_srstrb}, {31'h0, r0});
      if (r0) begin e.owner = 1'b0; e.data = exp_rd; e.due = cyc + 1; sb_q.push_back(e); end
    end else if (g == 2) begin
      chk({tag, "_s_addr"}, a_saddr, ad1);
      chk({tag, "_s_wdata"}, a_swdata, d1);
      chk({tag, "_s_wmask"}, {28'h0, a_swmask}, {28'h0, w1});
      chk({tag, "_s_rstrb"}, {31'h0, a_srstrb}, {31'h0, r1});
      if (r1) begin e.owner = 1'b1; e.data = exp_rd; e.due = cyc + 1; sb_q.push_back(e); end
    end else begin
      chk({tag, "_s_addr"}, a_saddr, ad0);
      chk({tag, "_s_wdata"}, a_swdata, d0);
      chk({tag, "_s_wmask"}, {28'h0, a_swmask}, 32'h0);
      chk({tag, "_s_rstrb"}, {31'h0, a_srstrb}, 32'h0);
    end
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b0, 4'h0, 32'h44, 32'h5555_AAAA, 1'b0, 4'h0, 32'h48, 32'h0, 0, 32'h0, tag);
  endtask

  task automatic both_rd(input logic rn, input int g, input logic [31:0] exp_rd, input string tag);
    step(rn, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'h0, 32'h14, 32'h0, g, exp_rd, tag);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk(tag, {16'h0, a_cnt}, exp[31:0]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem_rr[i] = 32'h0; mem_fp[i] = 32'h0; end
    mem_rr[4] = 32'hDEAD_BEEF; mem_fp[4] = 32'hDEAD_BEEF;   // 0x10
    mem_rr[5] = 32'h1111_1111; mem_fp[5] = 32'h1111_1111;   // 0x14
    mem_rr[8] = 32'h1234_5678; mem_fp[8] = 32'h1234_5678;   // 0x20
    mem_rr[9] = 32'hCAFE_F00D; mem_fp[9] = 32'hCAFE_F00D;   // 0x24

    // Reset with both masters requesting: nothing granted
    both_rd(1'b0, 0, 32'h0, "rst");
    both_rd(1'b0, 0, 32'h0, "rst");
    chk_cnt("rst_cnt", 0);

    // Round-robin from reset: m0 first, then alternating
    both_rd(1'b1, 1, 32'hDEAD_BEEF, "rr_a"); chk_cnt("rr_cnt0", 0);
    both_rd(1'b1, 2, 32'h1111_1111, "rr_b"); chk_cnt("rr_cnt1", 1);
    both_rd(1'b1, 1, 32'hDEAD_BEEF, "rr_c"); chk_cnt("rr_cnt2", 2);
    both_rd(1'b1, 2, 32'h1111_1111, "rr_d"); chk_cnt("rr_cnt3", 3);
    idle("rr_idle");                          chk_cnt("rr_cnt4", 4);

    // Single m0 read
    step(1'b1, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h14, 32'h0, 1, 32'hDEAD_BEEF, "m0rd");
    idle("idle1");

    // m1 byte-2 write (no read return), then m0 reads it back
    step(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, 4'b0100, 32'h20, 32'h00AB_0000, 2, 32'h0, "m1wr");
    step(1'b1, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h14, 32'h0, 1, 32'h12AB_5678, "m0rd20");

    // m0 write+read in one request: read returns pre-write word
    step(1'b1, 1'b1, 4'b0001, 32'h24, 32'h0000_00CC, 1'b0, 4'h0, 32'h14, 32'h0, 1, 32'hCAFE_F00D, "m0rw");
    step(1'b1, 1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 4'h0, 32'h14, 32'h0, 1, 32'hCAFE_F0CC, "m0rd24");

    // Back-to-back single requests from alternating masters
    step(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, "alt1");
    step(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 4'h0, 32'h48, 32'h0, 1, 32'h1111_1111, "alt2");

    // Reset lands right after an m0 read grant: its rvalid must never appear
    step(1'b1, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h14, 32'h0, 1, 32'hDEAD_BEEF, "pre_rst");
    void'(sb_q.pop_back());
    both_rd(1'b0, 0, 32'h0, "rst2");
    both_rd(1'b0, 0, 32'h0, "rst2");
    chk_cnt("rst2_cnt", 0);
    both_rd(1'b1, 1, 32'hDEAD_BEEF, "post_rst_a");
    both_rd(1'b1, 2, 32'h1111_1111, "post_rst_b");
    idle("idle2");

    // Saturation of the 4-bit counter under continuous write conflicts
    both_rd(1'b0, 0, 32'h0, "rst3");
    both_rd(1'b0, 0, 32'h0, "rst3");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 4'b0001, 32'h30, 32'h0, 1'b0, 4'b0001, 32'h34, 32'h0,
           (i % 2 == 0) ? 1 : 2, 32'h0, "sat");
      chk_cnt("sat_cnt", (i < 15) ? i : 15);
    end
    idle("sat_idle");
    chk_cnt("sat_hold", 15);

    // Fixed-priority instance: m0 always wins, m1 served once m0 goes idle
    active = 1;
    both_rd(1'b0, 0, 32'h0, "rst4");
    both_rd(1'b0, 0, 32'h0, "rst4");
    for (int j = 0; j < 5; j++) both_rd(1'b1, 1, 32'hDEAD_BEEF, "fp");
    step(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 4'h0, 32'h14, 32'h0, 2, 32'h1111_1111, "fp_m1");
    chk_cnt("fp_cnt", 5);
    idle("fp_idle");
    idle("fp_idle");
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence is short, so a stall means something broke
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
